seq: RTL and testbench
======================

// Module: seq
// PURPOSE
//   Serial bit-pattern detector. Samples one bit of `in` per rising clock edge and
//   raises `out` for one cycle each time the most recent PAT_LEN bits equal PATTERN.
//   Sits on a serial input stream as a framing/sync-word or trigger detector.
// PARAMETERS
//   PAT_LEN  3       pattern length in bits, 1..16
//   PATTERN  3'b101  target sequence, width PAT_LEN; MSB is the oldest bit received
//   OVERLAP  1       1: a match's trailing bits can start the next match; 0: they cannot
// PORTS
//   clk        input   1  clock; all state changes on the rising edge
//   rst        input   1  synchronous reset, active-high
//   in         input   1  serial data bit, sampled on each rising edge of clk
//   out        output  1  match pulse, high for one cycle per detected match
//   match_cnt  output  8  saturating match count (present only with SEQ_MATCH_COUNT_EN)
// BEHAVIOUR
// - One clock; reset is synchronous and active-high (clk, rst).
// - rst has priority over all other activity. On a rising edge with rst=1:
//   history <= 0, fill <= 0, out <= 0, match_cnt <= 0. The `in` bit on that edge is discarded.
// - State: history[PAT_LEN-1:0] is a shift register, new bit enters at the LSB.
//   fill is a saturating count 0..PAT_LEN of valid bits held since reset or since the last
//   non-overlapping match.
// - On each edge with rst=0: history <= {history[PAT_LEN-2:0], in}; fill <= min(fill+1, PAT_LEN).
// - match_next = (fill_next == PAT_LEN) && (history_next == PATTERN).
// - out is registered: out <= match_next. out is high during the cycle that follows the edge
//   sampling the final pattern bit. Latency is 1 edge, and out is never high two cycles in a row
//   unless the pattern permits it. For example, PATTERN=3'b111 with a stream of ones gives out=1
//   on every cycle when OVERLAP=1.
// - OVERLAP=0: on a match, fill <= 0 instead of PAT_LEN. The next match needs PAT_LEN fresh bits.
// - fill gating stops false matches from reset-cleared history. For example, PATTERN=3'b000
//   must not fire until 3 real zeros have been sampled after reset.
// - Before the first reset, outputs are undefined. Behaviour is defined only after rst is
//   asserted for at least one edge.
// - Reset mid-stream discards partial progress. Bits sampled before the reset edge can never
//   contribute to a match.
// CONFIGURATION
// - SEQ_MATCH_COUNT_EN defined: adds output match_cnt[7:0].
//   - Increments on every edge where match_next=1.
//   - Saturates at 255 and does not wrap.
//   - Cleared by rst.
// - SEQ_MATCH_COUNT_EN undefined: the match_cnt port and its counter logic do not exist.
//   All other behaviour is identical.
// TESTING (defaults unless noted; one bit per edge)
// 1. rst=1 for 2 edges with in toggling -> out=0 (and match_cnt=0) after each edge.
// 2. After reset, in=1,0,1 -> out=0,0,1 after the 3 edges, then out=0 on the next edge with in=0.
// 3. in=1,0,1,0,1 -> out=1 after edges 3 and 5 (match_cnt=2).
//    With OVERLAP=0 -> out=1 after edge 3 only (match_cnt=1).
// 4. in=1,0, then rst=1 for one edge, then in=1 -> out stays 0.
//    Continuing in=0,1 -> out=1 after that edge.
// 5. in=0,1,1,0,0,1,1 -> out=0 throughout.
//    PATTERN=3'b000: in=0,0 after reset -> no pulse; third 0 -> out=1.
// 6. SEQ_MATCH_COUNT_EN, in repeating 1,0 for 600 edges -> match_cnt saturates at 255.
//    Then rst -> match_cnt=0.

Source files
------------

// File: rtl/seq.sv
//==============================================================================
// Module      : seq
// Description : Serial bit-pattern detector. One bit of `in` is sampled on
//               each rising clock edge. `out` pulses for one cycle whenever
//               the most recent PAT_LEN bits equal PATTERN. Typical uses are
//               sync-word, framing and trigger detection on a serial stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   PAT_LEN   pattern length in bits, 1..16
//   PATTERN   target sequence; MSB is the oldest bit received
//   OVERLAP   1: a match's trailing bits may begin the next match
//             0: each match needs PAT_LEN fresh bits
// Ports
//   clk        in   1  clock; all state changes on the rising edge
//   rst        in   1  synchronous reset, active-high, priority over all else
//   in         in   1  serial data bit
//   out        out  1  registered match pulse
//   match_cnt  out  8  saturating match count (only with SEQ_MATCH_COUNT_EN)
// Build option
//   SEQ_MATCH_COUNT_EN  when defined, adds the match_cnt port and its counter
//==============================================================================
`default_nettype none

module seq #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
`ifdef SEQ_MATCH_COUNT_EN
    output logic       out,
    output logic [7:0] match_cnt
`else
    output logic       out
`endif
);

    // fill counts 0..PAT_LEN, so it needs enough bits to hold PAT_LEN itself.
    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] history_q;
    logic [PAT_LEN-1:0] history_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_inc;
    logic [FILL_W-1:0]  fill_d;
    logic               match_next;
    logic               out_q;

    // A one-bit pattern has no older bits to shift, so the history is
    // simply the newest sample.
    generate
        if (PAT_LEN == 1) begin : g_len1
            assign history_d = in;
        end else begin : g_lenn
            assign history_d = {history_q[PAT_LEN-2:0], in};
        end
    endgenerate

    always_comb begin
        fill_inc   = (fill_q == C_FULL) ? C_FULL : fill_q + 1'b1;
        // Gating on fill keeps reset-cleared history from looking like
        // real zeros (matters for patterns such as all-zeros).
        match_next = (fill_inc == C_FULL) && (history_d == PATTERN);
        // Without overlap, a match consumes its bits: restart the fill
        // so the next match needs PAT_LEN new samples.
        fill_d     = (match_next && !OVERLAP) ? '0 : fill_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            out_q     <= match_next;
        end
    end

    assign out = out_q;

`ifdef SEQ_MATCH_COUNT_EN
    logic [7:0] match_cnt_q;

    // Saturating count: holds at 255 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= 8'd0;
        end else if (match_next && (match_cnt_q != 8'hFF)) begin
            match_cnt_q <= match_cnt_q + 8'd1;
        end
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq.sv
//==============================================================================
// Module      : tb_seq
// Description : Directed self-checking bench for seq. Three instances share
//               the same stimulus: default (101, overlap), non-overlapping
//               101, and pattern 000. Counter checks are compiled in only
//               when SEQ_MATCH_COUNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq;

    logic clk;
    logic rst;
    logic in;
    logic out_d;
    logic out_n;
    logic out_z;
`ifdef SEQ_MATCH_COUNT_EN
    logic [7:0] cnt_d;
    logic [7:0] cnt_n;
    logic [7:0] cnt_z;
`endif

    int tests_run;
    int tests_failed;

    seq #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
`ifdef SEQ_MATCH_COUNT_EN
        .out       (out_d),
        .match_cnt (cnt_d)
`else
        .out       (out_d)
`endif
    );

    seq #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_novl (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
`ifdef SEQ_MATCH_COUNT_EN
        .out       (out_n),
        .match_cnt (cnt_n)
`else
        .out       (out_n)
`endif
    );

    seq #(.PAT_LEN(3), .PATTERN(3'b000), .OVERLAP(1'b1)) u_zero (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
`ifdef SEQ_MATCH_COUNT_EN
        .out       (out_z),
        .match_cnt (cnt_z)
`else
        .out       (out_z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit, let one rising edge sample it, then settle before checks.
    task automatic step(input logic b);
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic b);
        rst = 1'b1;
        step(b);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(logic'(i[0]));
            tests_run++;
            if ({out_d, out_n, out_z} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_out edge %0d: got %b%b%b want 000", i, out_d, out_n, out_z);
            end
`ifdef SEQ_MATCH_COUNT_EN
            tests_run++;
            if (cnt_d !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_cnt edge %0d: got %0d want 0", i, cnt_d);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic stim [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic expo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(stim[i]);
            tests_run++;
            if (out_d !== expo[i]) begin
                tests_failed++;
                $display("FAIL basic edge %0d: got %b want %b", i + 1, out_d, expo[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic stim [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic expd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic expn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(stim[i]);
            tests_run++;
            if (out_d !== expd[i]) begin
                tests_failed++;
                $display("FAIL overlap_on edge %0d: got %b want %b", i + 1, out_d, expd[i]);
            end
            tests_run++;
            if (out_n !== expn[i]) begin
                tests_failed++;
                $display("FAIL overlap_off edge %0d: got %b want %b", i + 1, out_n, expn[i]);
            end
        end
`ifdef SEQ_MATCH_COUNT_EN
        tests_run++;
        if (cnt_d !== 8'd2) begin
            tests_failed++;
            $display("FAIL overlap_on_cnt: got %0d want 2", cnt_d);
        end
        tests_run++;
        if (cnt_n !== 8'd1) begin
            tests_failed++;
            $display("FAIL overlap_off_cnt: got %0d want 1", cnt_n);
        end
`endif
    endtask

    task automatic test_mid_reset();
        // Entries flagged r are reset edges.
        logic stim [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic r    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic expo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            rst = r[i];
            step(stim[i]);
            tests_run++;
            if (out_d !== expo[i]) begin
                tests_failed++;
                $display("FAIL mid_reset edge %0d: got %b want %b", i + 1, out_d, expo[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_no_match();
        logic stim [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) begin
            step(stim[i]);
            tests_run++;
            if ({out_d, out_z} !== 2'b00) begin
                tests_failed++;
                $display("FAIL no_match edge %0d: got %b%b want 00", i + 1, out_d, out_z);
            end
        end
    endtask

    task automatic test_zero_pattern();
        logic expo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            tests_run++;
            if (out_z !== expo[i]) begin
                tests_failed++;
                $display("FAIL zero_pattern edge %0d: got %b want %b", i + 1, out_z, expo[i]);
            end
        end
    endtask

    // Stream 1,0,1,0,... for 600 edges: overlapping 101 matches on edges
    // 3,5,..,599 (299 matches); non-overlapping on edges 3,7,..,599 (150).
    task automatic test_long_stream();
        int pulses_d;
        int pulses_n;
        pulses_d = 0;
        pulses_n = 0;
        do_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            step(~logic'(i[0]));
            if (out_d === 1'b1) pulses_d++;
            if (out_n === 1'b1) pulses_n++;
        end
        tests_run++;
        if (pulses_d != 299) begin
            tests_failed++;
            $display("FAIL long_pulses_on: got %0d want 299", pulses_d);
        end
        tests_run++;
        if (pulses_n != 150) begin
            tests_failed++;
            $display("FAIL long_pulses_off: got %0d want 150", pulses_n);
        end
`ifdef SEQ_MATCH_COUNT_EN
        tests_run++;
        if (cnt_d !== 8'd255) begin
            tests_failed++;
            $display("FAIL cnt_saturate: got %0d want 255", cnt_d);
        end
        tests_run++;
        if (cnt_n !== 8'd150) begin
            tests_failed++;
            $display("FAIL cnt_off_150: got %0d want 150", cnt_n);
        end
        do_reset(1'b1);
        tests_run++;
        if (cnt_d !== 8'd0) begin
            tests_failed++;
            $display("FAIL cnt_clear: got %0d want 0", cnt_d);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in           = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_mid_reset();
        test_no_match();
        test_zero_pattern();
        test_long_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
